// File: rtl/lnrv_ifu_algn.sv
// Instruction aligner: splits word-aligned fetch responses into RV32/RV16 instructions for the IDU,
// carrying a leftover upper halfword across words and handling flush, misalignment and bus errors.
module lnrv_ifu_algn #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fch_rsp_vld,
    output logic        fch_rsp_rdy,
    input  logic [31:0] fch_rsp_data,
    input  logic [31:0] fch_rsp_addr,
    input  logic        fch_rsp_err,
    input  logic        pipe_flush_req,
    output logic        pipe_flush_ack,
    input  logic [31:0] flush_pc,
    output logic        ifu_ir_vld,
    input  logic        ifu_ir_rdy,
    output logic [31:0] ifu_ir,
    output logic [31:0] ifu_pc,
    output logic        ifu_misalgn,
    output logic        ifu_buserr
);

    typedef enum logic [1:0] {StRun, StSkip, StMis, StErrh} state_e;

    state_e      r_st,       w_st_nxt;
    logic        r_hw_vld,   w_hw_vld_nxt;
    logic [15:0] r_hw_data,  w_hw_data_nxt;
    logic [31:0] r_hw_pc,    w_hw_pc_nxt;
    logic [29:0] r_exp_wpc,  w_exp_wpc_nxt;

    logic        w_match;
    logic        w_stale;
    logic        w_hw16;
    logic        w_lo16;
    logic [31:0] w_wpc;
    logic [31:0] w_upc;
    logic        w_unused_addr;

    assign w_match       = fch_rsp_vld && (fch_rsp_addr[31:2] == r_exp_wpc);
    assign w_stale       = fch_rsp_vld && !w_match;
    assign w_hw16        = r_hw_vld && (r_hw_data[1:0] != 2'b11);
    assign w_lo16        = fch_rsp_data[1:0] != 2'b11;
    assign w_wpc         = {fch_rsp_addr[31:2], 2'b00};
    assign w_upc         = {fch_rsp_addr[31:2], 2'b10};
    assign w_unused_addr = ^fch_rsp_addr[1:0];

    assign pipe_flush_ack = pipe_flush_req;

    always_comb begin
        fch_rsp_rdy    = w_stale;
        ifu_ir_vld     = 1'b0;
        ifu_ir         = 32'h0;
        ifu_pc         = 32'h0;
        ifu_misalgn    = 1'b0;
        ifu_buserr     = 1'b0;
        w_st_nxt       = r_st;
        w_hw_vld_nxt   = r_hw_vld;
        w_hw_data_nxt  = r_hw_data;
        w_hw_pc_nxt    = r_hw_pc;
        w_exp_wpc_nxt  = r_exp_wpc;

        if (pipe_flush_req) begin
            fch_rsp_rdy   = 1'b1;
            w_hw_vld_nxt  = 1'b0;
            w_hw_pc_nxt   = flush_pc;
            w_exp_wpc_nxt = flush_pc[31:2];
            w_st_nxt      = flush_pc[0] ? StMis : (flush_pc[1] ? StSkip : StRun);
        end else begin
            unique case (r_st)
                StRun: begin
                    if (w_hw16) begin
                        // Pending RV16 goes out before anything from the next word, even an error.
                        ifu_ir_vld = 1'b1;
                        ifu_ir     = {16'h0, r_hw_data};
                        ifu_pc     = r_hw_pc;
                        if (ifu_ir_rdy) w_hw_vld_nxt = 1'b0;
                    end else if (w_match) begin
                        ifu_ir_vld  = 1'b1;
                        fch_rsp_rdy = ifu_ir_rdy;
                        if (ifu_ir_rdy) w_exp_wpc_nxt = r_exp_wpc + 30'd1;
                        if (fch_rsp_err) begin
                            ifu_buserr = 1'b1;
                            ifu_pc     = r_hw_vld ? r_hw_pc : w_wpc;
                            if (ifu_ir_rdy) begin
                                w_hw_vld_nxt = 1'b0;
                                w_st_nxt     = StErrh;
                            end
                        end else if (r_hw_vld) begin
                            ifu_ir = {fch_rsp_data[15:0], r_hw_data};
                            ifu_pc = r_hw_pc;
                            if (ifu_ir_rdy) begin
                                w_hw_data_nxt = fch_rsp_data[31:16];
                                w_hw_pc_nxt   = w_upc;
                            end
                        end else if (w_lo16) begin
                            ifu_ir = {16'h0, fch_rsp_data[15:0]};
                            ifu_pc = w_wpc;
                            if (ifu_ir_rdy) begin
                                w_hw_vld_nxt  = 1'b1;
                                w_hw_data_nxt = fch_rsp_data[31:16];
                                w_hw_pc_nxt   = w_upc;
                            end
                        end else begin
                            ifu_ir = fch_rsp_data;
                            ifu_pc = w_wpc;
                        end
                    end
                end
                StSkip: begin
                    if (w_match) begin
                        if (fch_rsp_err) begin
                            ifu_ir_vld  = 1'b1;
                            ifu_buserr  = 1'b1;
                            ifu_pc      = w_upc;
                            fch_rsp_rdy = ifu_ir_rdy;
                            if (ifu_ir_rdy) begin
                                w_exp_wpc_nxt = r_exp_wpc + 30'd1;
                                w_st_nxt      = StErrh;
                            end
                        end else begin
                            fch_rsp_rdy   = 1'b1;
                            w_hw_vld_nxt  = 1'b1;
                            w_hw_data_nxt = fch_rsp_data[31:16];
                            w_hw_pc_nxt   = w_upc;
                            w_exp_wpc_nxt = r_exp_wpc + 30'd1;
                            w_st_nxt      = StRun;
                        end
                    end
                end
                StMis: begin
                    // r_hw_pc holds the faulting flush target while in this state.
                    ifu_ir_vld  = 1'b1;
                    ifu_misalgn = 1'b1;
                    ifu_pc      = r_hw_pc;
                    fch_rsp_rdy = 1'b1;
                    if (ifu_ir_rdy) w_st_nxt = StErrh;
                end
                StErrh: begin
                    fch_rsp_rdy = 1'b1;
                end
                default: begin
                    fch_rsp_rdy = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_st      <= RESET_PC[1] ? StSkip : StRun;
            r_hw_vld  <= 1'b0;
            r_hw_data <= 16'h0;
            r_hw_pc   <= 32'h0;
            r_exp_wpc <= RESET_PC[31:2];
        end else begin
            r_st      <= w_st_nxt;
            r_hw_vld  <= w_hw_vld_nxt;
            r_hw_data <= w_hw_data_nxt;
            r_hw_pc   <= w_hw_pc_nxt;
            r_exp_wpc <= w_exp_wpc_nxt;
        end
    end

endmodule

// File: tb/tb_lnrv_ifu_algn.sv
// Bench for lnrv_ifu_algn: table of fetch words with expected instructions pushed to a scoreboard,
// plus hand sequences for flush, backpressure, bus error and misalignment.
module tb_lnrv_ifu_algn;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fch_rsp_vld = 1'b0;
    logic        fch_rsp_rdy;
    logic [31:0] fch_rsp_data = 32'h0;
    logic [31:0] fch_rsp_addr = 32'h0;
    logic        fch_rsp_err = 1'b0;
    logic        pipe_flush_req = 1'b0;
    logic        pipe_flush_ack;
    logic [31:0] flush_pc = 32'h0;
    logic        ifu_ir_vld;
    logic        ifu_ir_rdy = 1'b1;
    logic [31:0] ifu_ir;
    logic [31:0] ifu_pc;
    logic        ifu_misalgn;
    logic        ifu_buserr;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic        mis;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        imm_rdy;
        int          n_exp;
        logic [31:0] ir0;
        logic [31:0] pc0;
        logic [31:0] ir1;
        logic [31:0] pc1;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];

    always #5 clk = ~clk;

    lnrv_ifu_algn #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .fch_rsp_vld    (fch_rsp_vld),
        .fch_rsp_rdy    (fch_rsp_rdy),
        .fch_rsp_data   (fch_rsp_data),
        .fch_rsp_addr   (fch_rsp_addr),
        .fch_rsp_err    (fch_rsp_err),
        .pipe_flush_req (pipe_flush_req),
        .pipe_flush_ack (pipe_flush_ack),
        .flush_pc       (flush_pc),
        .ifu_ir_vld     (ifu_ir_vld),
        .ifu_ir_rdy     (ifu_ir_rdy),
        .ifu_ir         (ifu_ir),
        .ifu_pc         (ifu_pc),
        .ifu_misalgn    (ifu_misalgn),
        .ifu_buserr     (ifu_buserr)
    );

    task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] ir, input logic [31:0] pc, input logic mis,
                        input logic err);
        exp_t e;
        e.ir = ir; e.pc = pc; e.mis = mis; e.err = err;
        sb.push_back(e);
    endtask

    // Scoreboard: every instruction handed over to the IDU must match the next expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && ifu_ir_vld && ifu_ir_rdy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ir", {ifu_ir, ifu_pc, ifu_misalgn, ifu_buserr, 2'b01},
                        68'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ir", {ifu_ir, ifu_pc, ifu_misalgn, ifu_buserr, 2'b00},
                        {e.ir, e.pc, e.mis, e.err, 2'b00});
                end
            end
        end
    end

    // Present one word; checks its first-cycle ready and waits (bounded) for acceptance.
    task automatic send(input string nm, input logic [31:0] a, input logic [31:0] d,
                        input logic e, input logic imm);
        int n;
        n = 0;
        fch_rsp_vld = 1'b1; fch_rsp_addr = a; fch_rsp_data = d; fch_rsp_err = e;
        @(negedge clk);
        chk({nm, "_first_rdy"}, {67'h0, fch_rsp_rdy}, {67'h0, imm});
        while (!fch_rsp_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!fch_rsp_rdy) chk({nm, "_accept_timeout"}, 68'h0, 68'h1);
        @(posedge clk); #1;
        fch_rsp_vld = 1'b0; fch_rsp_err = 1'b0;
    endtask

    task automatic wait_empty(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_sb_empty"}, 68'(sb.size()), 68'h0);
    endtask

    task automatic flush(input logic [31:0] pc);
        pipe_flush_req = 1'b1; flush_pc = pc;
        @(negedge clk);
        chk("flush_cycle", {65'h0, pipe_flush_ack, ifu_ir_vld, fch_rsp_rdy}, {65'h0, 3'b101});
        @(posedge clk); #1;
        pipe_flush_req = 1'b0;
    endtask

    initial begin
        logic [31:0] hold_ir;

        vecs[0] = '{32'h0,  32'h00A0_0093, 1'b1, 1, 32'h00A0_0093, 32'h0, 32'h0, 32'h0};
        vecs[1] = '{32'h4,  32'h4501_4085, 1'b1, 2, 32'h0000_4085, 32'h4, 32'h0000_4501, 32'h6};
        vecs[2] = '{32'h8,  32'h0093_4085, 1'b0, 1, 32'h0000_4085, 32'h8, 32'h0, 32'h0};
        vecs[3] = '{32'hC,  32'h1234_00A0, 1'b1, 2, 32'h00A0_0093, 32'hA, 32'h0000_1234, 32'hE};
        vecs[4] = '{32'h10, 32'h0000_0013, 1'b0, 1, 32'h0000_0013, 32'h10, 32'h0, 32'h0};
        vecs[5] = '{32'h14, 32'h0001_0001, 1'b1, 2, 32'h0000_0001, 32'h14, 32'h0000_0001, 32'h16};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {ifu_ir_vld, fch_rsp_rdy, ifu_ir, ifu_pc, ifu_misalgn, ifu_buserr},
            68'h0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            push(vecs[i].ir0, vecs[i].pc0, 1'b0, 1'b0);
            if (vecs[i].n_exp > 1) push(vecs[i].ir1, vecs[i].pc1, 1'b0, 1'b0);
            send($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, 1'b0, vecs[i].imm_rdy);
        end
        wait_empty("table");

        // Flush to a halfword target: stale word dropped, lower half skipped.
        flush(32'h102);
        push(32'h0000_4501, 32'h102, 1'b0, 1'b0);
        send("stale", 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1);
        send("skip", 32'h100, 32'h4501_FFFF, 1'b0, 1'b1);
        wait_empty("skip");

        // Backpressure holds the full-word instruction at 0x104.
        ifu_ir_rdy = 1'b0;
        push(32'h00A0_0093, 32'h104, 1'b0, 1'b0);
        fch_rsp_vld = 1'b1; fch_rsp_addr = 32'h104; fch_rsp_data = 32'h00A0_0093;
        hold_ir = 32'h00A0_0093;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d", k), {ifu_ir_vld, fch_rsp_rdy, ifu_ir, ifu_pc, 2'b00},
                {1'b1, 1'b0, hold_ir, 32'h104, 2'b00});
            @(posedge clk); #1;
        end
        ifu_ir_rdy = 1'b1;
        @(negedge clk);
        chk("bp_release_rdy", {67'h0, fch_rsp_rdy}, 68'h1);
        @(posedge clk); #1;
        fch_rsp_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1 wait_empty("bp");

        // Bus error, then drain while halted.
        flush(32'h20);
        push(32'h0, 32'h20, 1'b0, 1'b1);
        send("err", 32'h20, 32'h0000_0013, 1'b1, 1'b1);
        send("drain", 32'h24, 32'h0000_0013, 1'b0, 1'b1);
        @(negedge clk);
        chk("errh_idle", {67'h0, ifu_ir_vld}, 68'h0);
        @(posedge clk); #1;
        wait_empty("err");

        // Misaligned flush target.
        flush(32'h201);
        push(32'h0, 32'h201, 1'b1, 1'b0);
        wait_empty("mis");
        send("mis_drain", 32'h200, 32'h0000_0013, 1'b0, 1'b1);
        @(negedge clk);
        chk("mis_after", {67'h0, ifu_ir_vld}, 68'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
